// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces NKEYS active-low push-buttons.
// Each key has an independent lane: a two-flop synchronizer, a debounce
// counter that accepts a level change after DB_CYCLES consecutive mismatching
// samples, and registered one-cycle press / release pulses.
//
// Optional feature, macro KEY_DEBOUNCE_REPEAT_EN: when defined, every lane also
// gets an auto-repeat state machine. It emits extra press pulses while a key is
// held and drives held during the repeat phase. When undefined, held is tied to
// 0 and REPEAT_DELAY / REPEAT_RATE are only range-checked.
//
// The release pulse port is named release_pulse because `release` is a
// reserved word in SystemVerilog.
//
// Lane state machine (KEY_DEBOUNCE_REPEAT_EN only):
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | key released, or level not yet accepted; no repeat activity
//   S_DELAY  | key accepted; counting REPEAT_DELAY cycles to first repeat
//   S_REPEAT | key still held; press pulse every REPEAT_RATE cycles, held=1

module key_debounce #(
  parameter int NKEYS        = 4,
  parameter int DB_CYCLES    = 16,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NKEYS-1:0] key_n,
  output logic [NKEYS-1:0] level,
  output logic [NKEYS-1:0] press,
  output logic [NKEYS-1:0] release_pulse,
  output logic [NKEYS-1:0] held
);

  localparam int              DB_W    = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // Reject parameter values the counters cannot represent sensibly.
  if (DB_CYCLES < 2) begin : g_bad_db_cycles
    $error("key_debounce: DB_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY < 2) begin : g_bad_repeat_delay
    $error("key_debounce: REPEAT_DELAY must be at least 2");
  end
  if (REPEAT_RATE < 2) begin : g_bad_repeat_rate
    $error("key_debounce: REPEAT_RATE must be at least 2");
  end

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } lane_state_t;
`endif

  for (genvar k = 0; k < NKEYS; k++) begin : g_lane
    logic            sync1;
    logic            sync2;
    logic            level_q;
    logic            press_q;
    logic            release_q;
    logic            held_q;
    logic [DB_W-1:0] db_cnt;
    logic            db_mismatch;
    logic            db_accept;
    logic            db_rise;
    logic            db_fall;

    // An accepted change happens on the edge where the counter is terminal
    // and the synchronized input still disagrees with the current level.
    assign db_mismatch = sync2 ^ level_q;
    assign db_accept   = db_mismatch && (db_cnt == DB_LAST);
    assign db_rise     = db_accept && !level_q;
    assign db_fall     = db_accept && level_q;

    // Two-flop synchronizer; inverts so sync2 is high while pressed.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
      end else begin
        sync1 <= ~key_n[k];
        sync2 <= sync1;
      end
    end

    // Debounce counter: counts consecutive mismatches, toggles level at terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        db_cnt  <= '0;
        level_q <= 1'b0;
      end else if (!db_mismatch) begin
        db_cnt <= '0;
      end else if (db_accept) begin
        db_cnt  <= '0;
        level_q <= ~level_q;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end

`ifdef KEY_DEBOUNCE_REPEAT_EN
    lane_state_t      state;
    logic [RPT_W-1:0] rpt_cnt;

    // Lane FSM with registered press/release/held; a fall overrides any repeat.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state     <= S_IDLE;
        rpt_cnt   <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        held_q    <= 1'b0;
      end else begin
        press_q   <= db_rise;
        release_q <= db_fall;
        if (db_fall) begin
          state   <= S_IDLE;
          rpt_cnt <= '0;
          held_q  <= 1'b0;
        end else begin
          case (state)
            S_IDLE: begin
              held_q <= 1'b0;
              if (db_rise) begin
                state   <= S_DELAY;
                rpt_cnt <= '0;
              end
            end
            S_DELAY: begin
              if (rpt_cnt == DELAY_LAST) begin
                press_q <= 1'b1;
                rpt_cnt <= '0;
                state   <= S_REPEAT;
                held_q  <= 1'b1;
              end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
              end
            end
            S_REPEAT: begin
              if (rpt_cnt == RATE_LAST) begin
                press_q <= 1'b1;
                rpt_cnt <= '0;
              end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
              end
            end
            default: begin
              state   <= S_IDLE;
              rpt_cnt <= '0;
              held_q  <= 1'b0;
            end
          endcase
        end
      end
    end
`else
    // Single press pulse per accepted press, single release pulse per release.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= db_rise;
        release_q <= db_fall;
      end
    end

    assign held_q = 1'b0;
`endif

    assign level[k]         = level_q;
    assign press[k]         = press_q;
    assign release_pulse[k] = release_q;
    assign held[k]          = held_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_RATE=5. Step s counts falling clock edges after the key input was
// changed; a change at step 0 is first sampled on the following rising edge,
// so an accepted level change becomes visible at step DB_CYCLES+2 = 6.
module tb_key_debounce;

  localparam int NKEYS        = 4;
  localparam int DB_CYCLES    = 4;
  localparam int REPEAT_DELAY = 20;
  localparam int REPEAT_RATE  = 5;
  localparam int LAT          = DB_CYCLES + 2;
  localparam int FIRST_RPT    = LAT + REPEAT_DELAY;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NKEYS-1:0] key_n = 4'b1111;
  logic [NKEYS-1:0] level;
  logic [NKEYS-1:0] press;
  logic [NKEYS-1:0] release_pulse;
  logic [NKEYS-1:0] held;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  key_debounce #(
    .NKEYS       (NKEYS),
    .DB_CYCLES   (DB_CYCLES),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_n        (key_n),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .held         (held)
  );

  task automatic step();
    @(negedge clk);
  endtask

  // Model of one lane whose key is held low from step 0 until step hold.
  function automatic bit m_level(int s, int hold);
    return (s >= LAT) && (s < hold + LAT);
  endfunction

  function automatic bit m_press(int s, int hold);
    bit p;
    p = (s == LAT);
`ifdef KEY_DEBOUNCE_REPEAT_EN
    if (s >= FIRST_RPT && ((s - FIRST_RPT) % REPEAT_RATE) == 0) p = 1'b1;
`endif
    return p && (s < hold + LAT);
  endfunction

  function automatic bit m_held(int s, int hold);
`ifdef KEY_DEBOUNCE_REPEAT_EN
    return (s >= FIRST_RPT) && (s < hold + LAT);
`else
    return 1'b0 && (s == hold);
`endif
  endfunction

  function automatic bit m_release(int s, int hold);
    return s == hold + LAT;
  endfunction

  task automatic test_reset();
    logic [3:0] exp_level;
    logic [3:0] exp_press;
    logic [3:0] exp_rel;
    reset_n = 1'b0;
    key_n   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({level, press, release_pulse, held} !== 16'h0000)
        $display("FAIL reset_hold: got level=%b press=%b release=%b held=%b expected all 0",
                 level, press, release_pulse, held);
      else passes++;
    end
    reset_n = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      step();
      exp_level = (s >= LAT) ? 4'b1111 : 4'b0000;
      exp_press = (s == LAT) ? 4'b1111 : 4'b0000;
      checks++;
      if (level !== exp_level)
        $display("FAIL reset_release_level step %0d: got %b expected %b", s, level, exp_level);
      else passes++;
      checks++;
      if (press !== exp_press)
        $display("FAIL reset_release_press step %0d: got %b expected %b", s, press, exp_press);
      else passes++;
    end
    key_n = 4'b1111;
    for (int s = 1; s <= 10; s++) begin
      step();
      exp_level = (s >= LAT) ? 4'b0000 : 4'b1111;
      exp_rel   = (s == LAT) ? 4'b1111 : 4'b0000;
      checks++;
      if (level !== exp_level || release_pulse !== exp_rel || press !== 4'b0000)
        $display("FAIL reset_key_up step %0d: got level=%b release=%b press=%b expected level=%b release=%b press=0000",
                 s, level, release_pulse, press, exp_level, exp_rel);
      else passes++;
    end
  endtask

  task automatic test_clean_press();
    localparam int HOLD = 40;
    logic [3:0] e_level, e_press, e_rel, e_held;
    key_n = 4'b1110;
    for (int s = 1; s <= HOLD + LAT + 6; s++) begin
      step();
      e_level = {3'b000, m_level(s, HOLD)};
      e_press = {3'b000, m_press(s, HOLD)};
      e_rel   = {3'b000, m_release(s, HOLD)};
      e_held  = {3'b000, m_held(s, HOLD)};
      checks++;
      if (level !== e_level || press !== e_press || release_pulse !== e_rel || held !== e_held)
        $display("FAIL clean_press step %0d: got level=%b press=%b release=%b held=%b expected level=%b press=%b release=%b held=%b",
                 s, level, press, release_pulse, held, e_level, e_press, e_rel, e_held);
      else passes++;
      if (s == HOLD) key_n = 4'b1111;
    end
  endtask

  task automatic test_bounce();
    int npress;
    for (int i = 0; i < 32; i++) begin
      key_n = ((i % 4) == 3) ? 4'b1111 : 4'b1101;
      step();
      checks++;
      if (level !== 4'b0000 || press !== 4'b0000)
        $display("FAIL bounce_reject cycle %0d: got level=%b press=%b expected 0000/0000", i, level, press);
      else passes++;
    end
    key_n  = 4'b1101;
    npress = 0;
    for (int s = 1; s <= 10; s++) begin
      step();
      if (press[1]) npress++;
      checks++;
      if (press !== ((s == LAT) ? 4'b0010 : 4'b0000))
        $display("FAIL bounce_stable_press step %0d: got %b expected %b",
                 s, press, (s == LAT) ? 4'b0010 : 4'b0000);
      else passes++;
    end
    checks++;
    if (npress !== 1 || level !== 4'b0010)
      $display("FAIL bounce_final: got presses=%0d level=%b expected presses=1 level=0010", npress, level);
    else passes++;
    key_n = 4'b1111;
    for (int s = 1; s <= 10; s++) step();
    checks++;
    if (level !== 4'b0000)
      $display("FAIL bounce_released: got level=%b expected 0000", level);
    else passes++;
  endtask

  task automatic test_auto_repeat();
    localparam int HOLD = 60;
    logic [3:0] e_level, e_press, e_rel, e_held;
    int npress;
    npress = 0;
    key_n  = 4'b1011;
    for (int s = 1; s <= HOLD + LAT + 20; s++) begin
      step();
      if (press[2]) npress++;
      e_level = {1'b0, m_level(s, HOLD), 2'b00};
      e_press = {1'b0, m_press(s, HOLD), 2'b00};
      e_rel   = {1'b0, m_release(s, HOLD), 2'b00};
      e_held  = {1'b0, m_held(s, HOLD), 2'b00};
      checks++;
      if (level !== e_level || press !== e_press || release_pulse !== e_rel || held !== e_held)
        $display("FAIL auto_repeat step %0d: got level=%b press=%b release=%b held=%b expected level=%b press=%b release=%b held=%b",
                 s, level, press, release_pulse, held, e_level, e_press, e_rel, e_held);
      else passes++;
      if (s == HOLD) key_n = 4'b1111;
    end
    checks++;
`ifdef KEY_DEBOUNCE_REPEAT_EN
    if (npress !== 9)
      $display("FAIL auto_repeat_count: got %0d pulses expected 9", npress);
    else passes++;
`else
    if (npress !== 1)
      $display("FAIL auto_repeat_count: got %0d pulses expected 1", npress);
    else passes++;
`endif
  endtask

  task automatic test_simultaneous_reset();
    logic [3:0] e_level, e_press;
    key_n = 4'b0110;
    for (int s = 1; s <= 9; s++) begin
      step();
      e_level = (s >= LAT) ? 4'b1001 : 4'b0000;
      e_press = (s == LAT) ? 4'b1001 : 4'b0000;
      checks++;
      if (level !== e_level || press !== e_press)
        $display("FAIL simultaneous step %0d: got level=%b press=%b expected level=%b press=%b",
                 s, level, press, e_level, e_press);
      else passes++;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (level !== 4'b0000 || release_pulse !== 4'b0000 || press !== 4'b0000 || held !== 4'b0000)
      $display("FAIL reset_mid_hold_async: got level=%b release=%b press=%b held=%b expected all 0",
               level, release_pulse, press, held);
    else passes++;
    for (int i = 0; i < 3; i++) step();
    key_n   = 4'b1111;
    reset_n = 1'b1;
    for (int s = 1; s <= 10; s++) begin
      step();
      checks++;
      if ({level, press, release_pulse, held} !== 16'h0000)
        $display("FAIL reset_mid_hold_after step %0d: got level=%b press=%b release=%b held=%b expected all 0",
                 s, level, press, release_pulse, held);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_simultaneous_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
